// File: rtl/dds_key_ctrl.sv
// dds_key_ctrl: frequency-control-word sequencer for a DDS phase accumulator.
// Two active-low keys step through a 4-entry K table; sweep_en selects an
// automatic linear sweep from K0 up to the K3 ceiling, wrapping back to K0.
module dds_key_ctrl #(
  parameter int unsigned DB_CYCLES  = 1000000,
  parameter int unsigned SWEEP_DIV  = 50000,
  parameter logic [31:0] SWEEP_STEP = 32'd85899,
  parameter logic [31:0] K0         = 32'd85899,
  parameter logic [31:0] K1         = 32'd858993,
  parameter logic [31:0] K2         = 32'd8589935,
  parameter logic [31:0] K3         = 32'd85899346
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up_n,
  input  logic        key_dn_n,
  input  logic        sweep_en,
  output logic [31:0] k_out,
  output logic [1:0]  sel_idx,
  output logic        k_valid,
  output logic        sweeping
);

  localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned DVW = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(SWEEP_DIV - 1);

  typedef enum logic {
    ST_MANUAL,
    ST_SWEEP
  } state_e;

  // Bit 0 = up key, bit 1 = down key throughout the conditioning logic.
  logic [1:0]          keys_n;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          stable_q, stable_d;
  logic [1:0]          press_q, press_d;
  logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;

  state_e          state_q, state_d;
  logic [31:0]     k_q, k_d;
  logic [1:0]      sel_q, sel_d;
  logic            valid_q, valid_d;
  logic [DVW-1:0]  div_q, div_d;
  logic [32:0]     sum;

  assign keys_n = {key_dn_n, key_up_n};

  function automatic logic [31:0] ktab(input logic [1:0] idx);
    case (idx)
      2'd0:    ktab = K0;
      2'd1:    ktab = K1;
      2'd2:    ktab = K2;
      default: ktab = K3;
    endcase
  endfunction

  // Two-flop synchronizers for the asynchronous raw keys (idle level is 1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= keys_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a new level must persist DB_CYCLES samples before it is accepted;
  // only the accepted 1->0 transition produces a press pulse.
  always_comb begin
    stable_d = stable_q;
    press_d  = '0;
    db_cnt_d = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
          press_d[i]  = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state and registered press pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '1;
      press_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Next-state logic: manual stepping, sweep entry/exit and sweep increments.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sel_d   = sel_q;
    div_d   = div_q;
    sum     = {1'b0, k_q} + {1'b0, SWEEP_STEP};
    case (state_q)
      ST_MANUAL: begin
        if (sweep_en) begin
          state_d = ST_SWEEP;
          k_d     = K0;
          div_d   = '0;
        end else if (press_q[0] && !press_q[1]) begin
          if (sel_q != 2'd3) begin
            sel_d = sel_q + 2'd1;
            k_d   = ktab(sel_q + 2'd1);
          end
        end else if (press_q[1] && !press_q[0]) begin
          if (sel_q != 2'd0) begin
            sel_d = sel_q - 2'd1;
            k_d   = ktab(sel_q - 2'd1);
          end
        end
      end
      ST_SWEEP: begin
        if (!sweep_en) begin
          state_d = ST_MANUAL;
          k_d     = ktab(sel_q);
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          k_d   = (sum > {1'b0, K3}) ? K0 : sum[31:0];
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_MANUAL;
    endcase
    // Every sweep step changes K, so "changed" covers all k_valid cases.
    valid_d = (k_d != k_q);
  end

  // Control state and fully registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_MANUAL;
      k_q     <= K0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      div_q   <= div_d;
    end
  end

  assign k_out    = k_q;
  assign sel_idx  = sel_q;
  assign k_valid  = valid_q;
  assign sweeping = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Testbench for dds_key_ctrl: table-driven key sequences, hand-written sweep
// and reset sequences, and a random phase checked against a reference model.
module tb_dds_key_ctrl;

  localparam int DB  = 8;
  localparam int DIV = 4;
  localparam logic [31:0] K0 = 32'd85899;
  localparam logic [31:0] K1 = 32'd858993;
  localparam logic [31:0] K2 = 32'd8589935;
  localparam logic [31:0] K3 = 32'd85899346;
  localparam longint STEP = 85899;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_up_n = 1'b1;
  logic        key_dn_n = 1'b1;
  logic        sweep_en = 1'b0;
  logic [31:0] k_out;
  logic [1:0]  sel_idx;
  logic        k_valid;
  logic        sweeping;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  dds_key_ctrl #(
    .DB_CYCLES(DB),
    .SWEEP_DIV(DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_up_n(key_up_n),
    .key_dn_n(key_dn_n),
    .sweep_en(sweep_en),
    .k_out(k_out),
    .sel_idx(sel_idx),
    .k_valid(k_valid),
    .sweeping(sweeping)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance n cycles, landing 1 time unit after each edge; counts k_valid pulses.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (k_valid) pulses++;
    end
  endtask

  // ---------------- reference model ----------------
  // Keys: raw samples kept in a window; a level is accepted once the last DB
  // synchronized samples (raw delayed by two samples) all show the new level.
  bit     qu[$], qd[$];
  bit     st_u, st_d, pu, pd;
  bit     m_sw, m_v;
  int     m_idx, since;
  longint m_k;

  function automatic longint tab(input int i);
    case (i)
      0: return longint'(K0);
      1: return longint'(K1);
      2: return longint'(K2);
      default: return longint'(K3);
    endcase
  endfunction

  function automatic bit win_all(input bit q[$], input bit v);
    for (int i = 0; i < DB; i++) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qu = {}; qd = {};
      for (int i = 0; i < DB + 2; i++) begin qu.push_back(1'b1); qd.push_back(1'b1); end
      st_u = 1; st_d = 1; pu = 0; pd = 0;
      m_sw = 0; m_v = 0; m_idx = 0; since = 0; m_k = longint'(K0);
    end else begin
      longint old;
      bit nu, nd;
      old = m_k;
      if (!m_sw) begin
        if (sweep_en) begin
          m_sw = 1; since = 0; m_k = longint'(K0);
        end else if (pu && !pd) begin
          m_idx = (m_idx < 3) ? m_idx + 1 : 3;
          m_k = tab(m_idx);
        end else if (pd && !pu) begin
          m_idx = (m_idx > 0) ? m_idx - 1 : 0;
          m_k = tab(m_idx);
        end
      end else begin
        if (!sweep_en) begin
          m_sw = 0; m_k = tab(m_idx);
        end else begin
          since++;
          if (since % DIV == 0) m_k = (m_k + STEP > longint'(K3)) ? longint'(K0) : m_k + STEP;
        end
      end
      m_v = (m_k != old);
      qu.push_back(key_up_n); void'(qu.pop_front());
      qd.push_back(key_dn_n); void'(qd.pop_front());
      nu = 0; nd = 0;
      if (win_all(qu, !st_u)) begin st_u = !st_u; nu = !st_u; end
      if (win_all(qd, !st_d)) begin st_d = !st_d; nd = !st_d; end
      pu = nu; pd = nd;
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("model", {28'd0, sweeping, k_valid, sel_idx, k_out},
        {28'd0, m_sw, m_v, m_idx[1:0], m_k[31:0]});
  end

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    bit          up;
    bit          dn;
    logic [31:0] exp_k;
    logic [1:0]  exp_sel;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n;
    logic [31:0] mx;

    vecs[0]  = '{"idle",      0, 0, K0, 2'd0, 0};
    vecs[1]  = '{"up1",       1, 0, K1, 2'd1, 1};
    vecs[2]  = '{"up2",       1, 0, K2, 2'd2, 1};
    vecs[3]  = '{"up3",       1, 0, K3, 2'd3, 1};
    vecs[4]  = '{"up_sat",    1, 0, K3, 2'd3, 0};
    vecs[5]  = '{"dn1",       0, 1, K2, 2'd2, 1};
    vecs[6]  = '{"dn2",       0, 1, K1, 2'd1, 1};
    vecs[7]  = '{"dn3",       0, 1, K0, 2'd0, 1};
    vecs[8]  = '{"dn_sat",    0, 1, K0, 2'd0, 0};
    vecs[9]  = '{"both",      1, 1, K0, 2'd0, 0};
    vecs[10] = '{"up_again1", 1, 0, K1, 2'd1, 1};
    vecs[11] = '{"up_again2", 1, 0, K2, 2'd2, 1};

    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_k", k_out, K0);
    chk("reset_sel", sel_idx, 0);
    chk("reset_valid", k_valid, 0);
    chk("reset_sweeping", sweeping, 0);

    for (int i = 0; i < 12; i++) begin
      pulses = 0;
      key_up_n = !vecs[i].up;
      key_dn_n = !vecs[i].dn;
      tick(20);
      key_up_n = 1'b1;
      key_dn_n = 1'b1;
      tick(20);
      chk({vecs[i].name, "_k"}, k_out, vecs[i].exp_k);
      chk({vecs[i].name, "_sel"}, sel_idx, vecs[i].exp_sel);
      chk({vecs[i].name, "_pulses"}, pulses, vecs[i].exp_pulses);
    end

    // Bouncing key never stays low long enough to be accepted.
    pulses = 0;
    repeat (5) begin
      key_up_n = 1'b0; tick(3);
      key_up_n = 1'b1; tick(3);
    end
    tick(20);
    chk("bounce_k", k_out, K2);
    chk("bounce_pulses", pulses, 0);

    // Sweep from index 2.
    sweep_en = 1'b1;
    tick(1);
    chk("sw_entry_k", k_out, K0);
    chk("sw_entry_valid", k_valid, 1);
    chk("sw_entry_sweeping", sweeping, 1);
    tick(3);
    chk("sw_hold_k", k_out, K0);
    tick(1);
    chk("sw_step1_k", k_out, 32'd171798);
    chk("sw_step1_valid", k_valid, 1);
    n = 0;
    mx = k_out;
    for (int c = 0; c < 5000 && k_out != K0; c++) begin
      tick(1);
      if (k_valid) n++;
      if (k_out > mx) mx = k_out;
    end
    chk("sw_wrap_k", k_out, K0);
    chk("sw_steps_to_wrap", n, 999);
    chk("sw_peak", mx, 32'd85899000);
    sweep_en = 1'b0;
    tick(1);
    chk("sw_exit_k", k_out, K2);
    chk("sw_exit_sel", sel_idx, 2);
    chk("sw_exit_sweeping", sweeping, 0);
    chk("sw_exit_valid", k_valid, 1);

    // Reset in the middle of a sweep.
    sweep_en = 1'b1;
    tick(37);
    #2 rst = 1'b1;
    sweep_en = 1'b0;
    #1;
    chk("midrst_k", k_out, K0);
    chk("midrst_sel", sel_idx, 0);
    chk("midrst_sweeping", sweeping, 0);
    chk("midrst_valid", k_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);

    // Random phase, checked by the model every cycle.
    for (int s = 0; s < 300; s++) begin
      key_up_n = ($urandom_range(0, 2) != 0);
      key_dn_n = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) sweep_en = !sweep_en;
      if ($urandom_range(0, 79) == 0) begin
        #3 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
      end
      tick($urandom_range(1, 30));
    end
    sweep_en = 1'b0;
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    tick(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
